// File: rtl/wb_timer.sv
// wb_timer: Wishbone classic-cycle slave that implements the machine timer.
// It holds a free-running 64-bit mtime with an 8-bit prescaler, a 64-bit
// mtimecmp, and drives a registered level interrupt when mtime >= mtimecmp.
//
// Ports:
//   clk_i        system clock, all state changes on its rising edge
//   rst_n_i      asynchronous active-low reset
//   wb_addr_i    word address, bits [4:2] select the register
//   wb_data_i    write data
//   wb_we_i      1 = write, 0 = read
//   wb_sel_i     byte enables for writes
//   wb_stb_i     strobe
//   wb_cyc_i     bus cycle
//   wb_ack_o     registered single-cycle acknowledge
//   wb_data_o    registered read data, valid while wb_ack_o is high
//   timer_irq_o  level machine-timer interrupt
//
// Register map (offset = addr[4:2] * 4):
//   0x00 MTIME_LO     read also snapshots mtime[63:32] into the HI shadow
//   0x04 MTIME_HI     read returns the shadow, write sets mtime[63:32]
//   0x08 MTIMECMP_LO
//   0x0C MTIMECMP_HI
//   0x10 CTRL         bit0 EN, bits[15:8] DIV
//   0x14 STATUS       bit0 = timer_irq_o, read only
//   0x18/0x1C         read 32'hDEAD_BEAF, writes ignored
module wb_timer #(
    parameter int WB_DATA_WIDTH = 32,
    parameter int WB_ADDR_WIDTH = 32,
    parameter int WB_SEL_WIDTH  = WB_DATA_WIDTH / 8
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic [WB_ADDR_WIDTH-1:0] wb_addr_i,
    input  logic [WB_DATA_WIDTH-1:0] wb_data_i,
    input  logic                     wb_we_i,
    input  logic [WB_SEL_WIDTH-1:0]  wb_sel_i,
    input  logic                     wb_stb_i,
    input  logic                     wb_cyc_i,
    output logic                     wb_ack_o,
    output logic [WB_DATA_WIDTH-1:0] wb_data_o,
    output logic                     timer_irq_o
);

    localparam logic [2:0] REG_MTIME_LO    = 3'd0;
    localparam logic [2:0] REG_MTIME_HI    = 3'd1;
    localparam logic [2:0] REG_MTIMECMP_LO = 3'd2;
    localparam logic [2:0] REG_MTIMECMP_HI = 3'd3;
    localparam logic [2:0] REG_CTRL        = 3'd4;
    localparam logic [2:0] REG_STATUS      = 3'd5;

    logic [63:0]              mtime_q, mtime_d;
    logic [63:0]              mtimecmp_q, mtimecmp_d;
    logic [31:0]              shadow_q, shadow_d;
    logic                     en_q, en_d;
    logic [7:0]               div_q, div_d;
    logic [7:0]               pcnt_q, pcnt_d;
    logic                     ack_q, ack_d;
    logic [WB_DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                     irq_q, irq_d;

    logic                     access;
    logic                     tick;
    logic [2:0]               reg_sel;
    logic [31:0]              ctrl_word;
    logic [31:0]              ctrl_merged;

    // Address bits outside [4:2] are decoded by the interconnect, not here.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{wb_addr_i[WB_ADDR_WIDTH-1:5], wb_addr_i[1:0]};

    // Replace only the byte lanes enabled by sel, keep the others.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                                input logic [31:0] new_w,
                                                input logic [3:0]  sel);
        logic [31:0] res;
        res = old_w;
        for (int b = 0; b < 4; b++) begin
            if (sel[b]) begin
                res[8*b +: 8] = new_w[8*b +: 8];
            end
        end
        return res;
    endfunction

    always_comb begin
        // An access is accepted only while no ack is outstanding, which
        // gives one access every two cycles under a held strobe.
        access    = wb_stb_i & wb_cyc_i & ~ack_q;
        reg_sel   = wb_addr_i[4:2];
        tick      = en_q && (pcnt_q == div_q);
        ctrl_word = {16'h0000, div_q, 7'b0000000, en_q};

        ack_d       = access;
        pcnt_d      = en_q ? (tick ? 8'd0 : pcnt_q + 8'd1) : pcnt_q;
        mtime_d     = mtime_q + {63'd0, tick};
        mtimecmp_d  = mtimecmp_q;
        shadow_d    = shadow_q;
        en_d        = en_q;
        div_d       = div_q;
        rdata_d     = rdata_q;
        ctrl_merged = merge_bytes(ctrl_word, wb_data_i, wb_sel_i);

        // Software writes overlay the already-incremented mtime, so the
        // written bytes win and the untouched bytes keep counting.
        if (access && wb_we_i) begin
            case (reg_sel)
                REG_MTIME_LO:    mtime_d[31:0]     = merge_bytes(mtime_d[31:0], wb_data_i, wb_sel_i);
                REG_MTIME_HI:    mtime_d[63:32]    = merge_bytes(mtime_d[63:32], wb_data_i, wb_sel_i);
                REG_MTIMECMP_LO: mtimecmp_d[31:0]  = merge_bytes(mtimecmp_q[31:0], wb_data_i, wb_sel_i);
                REG_MTIMECMP_HI: mtimecmp_d[63:32] = merge_bytes(mtimecmp_q[63:32], wb_data_i, wb_sel_i);
                REG_CTRL: begin
                    en_d   = ctrl_merged[0];
                    div_d  = ctrl_merged[15:8];
                    pcnt_d = 8'd0;
                end
                default: ;
            endcase
        end

        // Reading LO latches HI so a LO-then-HI pair is coherent.
        if (access && !wb_we_i) begin
            case (reg_sel)
                REG_MTIME_LO: begin
                    rdata_d  = mtime_q[31:0];
                    shadow_d = mtime_q[63:32];
                end
                REG_MTIME_HI:    rdata_d = shadow_q;
                REG_MTIMECMP_LO: rdata_d = mtimecmp_q[31:0];
                REG_MTIMECMP_HI: rdata_d = mtimecmp_q[63:32];
                REG_CTRL:        rdata_d = ctrl_word;
                REG_STATUS:      rdata_d = {31'd0, irq_q};
                default:         rdata_d = 32'hDEAD_BEAF;
            endcase
        end

        irq_d = en_q & (mtime_q >= mtimecmp_q);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            mtime_q    <= 64'd0;
            mtimecmp_q <= 64'hFFFF_FFFF_FFFF_FFFF;
            shadow_q   <= 32'd0;
            en_q       <= 1'b0;
            div_q      <= 8'd0;
            pcnt_q     <= 8'd0;
            ack_q      <= 1'b0;
            rdata_q    <= '0;
            irq_q      <= 1'b0;
        end else begin
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            shadow_q   <= shadow_d;
            en_q       <= en_d;
            div_q      <= div_d;
            pcnt_q     <= pcnt_d;
            ack_q      <= ack_d;
            rdata_q    <= rdata_d;
            irq_q      <= irq_d;
        end
    end

    assign wb_ack_o    = ack_q;
    assign wb_data_o   = rdata_q;
    assign timer_irq_o = irq_q;

endmodule

// File: tb/tb_wb_timer.sv
// tb_wb_timer: directed self-checking bench for wb_timer.
// Drives Wishbone accesses #1 after the rising edge and samples #1 after it.
module tb_wb_timer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] wbAddr = '0;
    logic [31:0] wbDataIn = '0;
    logic        wbWe = 1'b0;
    logic [3:0]  wbSel = '0;
    logic        wbStb = 1'b0;
    logic        wbCyc = 1'b0;
    logic        wbAck;
    logic [31:0] wbDataOut;
    logic        timerIrq;

    int checks = 0;
    int failures = 0;

    logic [31:0] rd;
    logic [31:0] frozenA;
    logic [31:0] frozenB;
    int          riseCycle;
    int          ackCount;

    wb_timer dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .wb_addr_i   (wbAddr),
        .wb_data_i   (wbDataIn),
        .wb_we_i     (wbWe),
        .wb_sel_i    (wbSel),
        .wb_stb_i    (wbStb),
        .wb_cyc_i    (wbCyc),
        .wb_ack_o    (wbAck),
        .wb_data_o   (wbDataOut),
        .timer_irq_o (timerIrq)
    );

    always #5 clk = ~clk;

    // Exact comparison, counted and reported on mismatch.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Inclusive range comparison for timing-alignment tolerant checks.
    task automatic checkRange(input string tag, input longint observed,
                              input longint lo, input longint hi);
        checks++;
        assert ((observed >= lo) && (observed <= hi)) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0d expected=%0d..%0d", tag, observed, lo, hi);
        end
    endtask

    // One Wishbone access; the ack must arrive on the first edge.
    task automatic applyStimulus(input logic we, input logic [31:0] addr,
                                 input logic [31:0] data, input logic [3:0] sel,
                                 output logic [31:0] rdata);
        @(posedge clk);
        #1;
        wbWe     = we;
        wbAddr   = addr;
        wbDataIn = data;
        wbSel    = sel;
        wbStb    = 1'b1;
        wbCyc    = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("access_ack", {63'd0, wbAck}, 64'd1);
        rdata = wbDataOut;
        wbStb = 1'b0;
        wbCyc = 1'b0;
        wbWe  = 1'b0;
    endtask

    initial begin
        $display("[TB] wb_timer bench start");
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_ack", {63'd0, wbAck}, 64'd0);
        checkOutput("reset_data", {32'd0, wbDataOut}, 64'd0);
        checkOutput("reset_irq", {63'd0, timerIrq}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset values of compare registers and the filler word.
        applyStimulus(1'b0, 32'h08, 32'h0, 4'h0, rd);
        checkOutput("rst_cmp_lo", {32'd0, rd}, 64'hFFFF_FFFF);
        applyStimulus(1'b0, 32'h0C, 32'h0, 4'h0, rd);
        checkOutput("rst_cmp_hi", {32'd0, rd}, 64'hFFFF_FFFF);
        checkOutput("rst_irq_idle", {63'd0, timerIrq}, 64'd0);
        applyStimulus(1'b0, 32'h1C, 32'h0, 4'h0, rd);
        checkOutput("filler_1c", {32'd0, rd}, 64'hDEAD_BEAF);
        applyStimulus(1'b0, 32'h10, 32'h0, 4'h0, rd);
        checkOutput("rst_ctrl", {32'd0, rd}, 64'd0);

        // Prescaler DIV 3: one tick every four cycles, 40 idle cycles.
        applyStimulus(1'b1, 32'h10, 32'h0000_0301, 4'hF, rd);
        repeat (40) @(posedge clk);
        applyStimulus(1'b0, 32'h00, 32'h0, 4'h0, rd);
        checkRange("div3_advance", longint'(rd), 9, 11);
        applyStimulus(1'b1, 32'h10, 32'h0000_0300, 4'hF, rd);
        applyStimulus(1'b0, 32'h00, 32'h0, 4'h0, frozenA);
        checkRange("freeze_value", longint'(frozenA), 10, 12);
        repeat (20) @(posedge clk);
        applyStimulus(1'b0, 32'h00, 32'h0, 4'h0, frozenB);
        checkOutput("freeze_hold", {32'd0, frozenB}, {32'd0, frozenA});

        // Carry from LO into HI, and the HI shadow behaviour.
        applyStimulus(1'b1, 32'h04, 32'h0, 4'hF, rd);
        applyStimulus(1'b1, 32'h00, 32'hFFFF_FFFE, 4'hF, rd);
        applyStimulus(1'b1, 32'h10, 32'h0000_0001, 4'hF, rd);
        repeat (3) @(posedge clk);
        applyStimulus(1'b0, 32'h00, 32'h0, 4'h0, rd);
        checkRange("carry_lo", longint'(rd), 1, 3);
        applyStimulus(1'b0, 32'h04, 32'h0, 4'h0, rd);
        checkOutput("carry_hi", {32'd0, rd}, 64'd1);
        applyStimulus(1'b1, 32'h10, 32'h0, 4'hF, rd);
        applyStimulus(1'b1, 32'h04, 32'h5, 4'hF, rd);
        applyStimulus(1'b0, 32'h04, 32'h0, 4'h0, rd);
        checkOutput("stale_shadow", {32'd0, rd}, 64'd1);
        applyStimulus(1'b0, 32'h00, 32'h0, 4'h0, rd);
        applyStimulus(1'b0, 32'h04, 32'h0, 4'h0, rd);
        checkOutput("fresh_shadow", {32'd0, rd}, 64'd5);

        // Interrupt rises when mtime reaches mtimecmp = 20.
        applyStimulus(1'b1, 32'h08, 32'd20, 4'hF, rd);
        applyStimulus(1'b1, 32'h0C, 32'd0, 4'hF, rd);
        applyStimulus(1'b1, 32'h00, 32'd0, 4'hF, rd);
        applyStimulus(1'b1, 32'h04, 32'd0, 4'hF, rd);
        checkOutput("irq_before_en", {63'd0, timerIrq}, 64'd0);
        applyStimulus(1'b1, 32'h10, 32'h0000_0001, 4'hF, rd);
        riseCycle = 0;
        for (int i = 1; i <= 30; i++) begin
            @(posedge clk);
            #1;
            if (timerIrq && riseCycle == 0) begin
                riseCycle = i;
            end
        end
        checkRange("irq_rise_cycle", longint'(riseCycle), 20, 22);
        applyStimulus(1'b0, 32'h14, 32'h0, 4'h0, rd);
        checkOutput("status_irq", {32'd0, rd}, 64'd1);
        applyStimulus(1'b1, 32'h0C, 32'd1, 4'hF, rd);
        checkOutput("irq_at_cmp_ack", {63'd0, timerIrq}, 64'd1);
        @(posedge clk);
        #1;
        checkOutput("irq_cleared", {63'd0, timerIrq}, 64'd0);

        // Byte-lane write on MTIME_LO while counting every cycle.
        applyStimulus(1'b1, 32'h10, 32'h0, 4'hF, rd);
        applyStimulus(1'b1, 32'h00, 32'h1234_5610, 4'hF, rd);
        applyStimulus(1'b1, 32'h04, 32'h0, 4'hF, rd);
        applyStimulus(1'b1, 32'h10, 32'h0000_0001, 4'hF, rd);
        applyStimulus(1'b1, 32'h00, 32'h0000_AB00, 4'b0010, rd);
        applyStimulus(1'b1, 32'h10, 32'h0, 4'hF, rd);
        applyStimulus(1'b0, 32'h00, 32'h0, 4'h0, rd);
        checkOutput("byte_lane_lo", {32'd0, rd}, 64'h1234_AB14);

        // CTRL only keeps EN and DIV; byte enables respected.
        applyStimulus(1'b1, 32'h10, 32'hFFFF_FF00, 4'hF, rd);
        applyStimulus(1'b0, 32'h10, 32'h0, 4'h0, rd);
        checkOutput("ctrl_mask", {32'd0, rd}, 64'h0000_FF00);
        applyStimulus(1'b1, 32'h10, 32'h0000_0001, 4'b0001, rd);
        applyStimulus(1'b0, 32'h10, 32'h0, 4'h0, rd);
        checkOutput("ctrl_sel", {32'd0, rd}, 64'h0000_FF01);
        applyStimulus(1'b1, 32'h10, 32'h0, 4'hF, rd);

        // Held strobe: one ack every other cycle.
        @(posedge clk);
        #1;
        wbAddr = 32'h14;
        wbWe   = 1'b0;
        wbStb  = 1'b1;
        wbCyc  = 1'b1;
        ackCount = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (wbAck) ackCount++;
        end
        checkOutput("held_stb_acks", 64'(ackCount), 64'd5);
        wbStb = 1'b0;
        wbCyc = 1'b0;
        @(posedge clk);
        #1;

        // Strobe without cycle is not an access.
        wbStb = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("stb_no_cyc", {63'd0, wbAck}, 64'd0);
        wbStb = 1'b0;

        // Asynchronous reset while ack is high.
        @(posedge clk);
        #1;
        wbStb = 1'b1;
        wbCyc = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("ack_before_reset", {63'd0, wbAck}, 64'd1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_reset_ack", {63'd0, wbAck}, 64'd0);
        wbStb = 1'b0;
        wbCyc = 1'b0;
        checkOutput("async_reset_data", {32'd0, wbDataOut}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b0, 32'h0C, 32'h0, 4'h0, rd);
        checkOutput("rereset_cmp_hi", {32'd0, rd}, 64'hFFFF_FFFF);
        applyStimulus(1'b0, 32'h10, 32'h0, 4'h0, rd);
        checkOutput("rereset_ctrl", {32'd0, rd}, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
